// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and oversampling constants for uart_core
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int OVERSAMPLE = 16;
  localparam int START_MID = 7;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator, reloads baud_div after each tick
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = (cnt == '0);
  // count down to zero, then pick up the current divisor
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= tick ? baud_div : cnt - DIV_W'(1);
endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex 16x-oversampled UART; define UART_PARITY_EN for a parity bit
module uart_core
  import uart_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int SB_TICK = 16,
  parameter int DIV_W = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [DIV_W-1:0] baud_div,
`ifdef UART_PARITY_EN
  input  logic             parity_odd,
`endif
  input  logic             tx_valid,
  input  logic [DBITS-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx,
  output logic             tx_busy,
  input  logic             rx,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic [DBITS-1:0] rx_data,
  output logic             rx_frame_err,
  output logic             rx_parity_err,
  output logic             rx_overrun
);
  localparam int CW = $clog2(SB_TICK > OVERSAMPLE ? SB_TICK : OVERSAMPLE);
  localparam int NW = $clog2(DBITS);
  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(SB_TICK - 1);
  localparam logic [CW-1:0] MID = CW'(START_MID);
  localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

  logic tick;
  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (.clk(PCLK), .rst(PRESET), .baud_div(baud_div), .tick(tick));

  uart_state_t tx_state;
  logic [CW-1:0] tx_cnt;
  logic [NW-1:0] tx_n;
  logic [DBITS-1:0] tx_sh;
  logic tx_last;
`ifdef UART_PARITY_EN
  logic tx_par;
`endif
  assign tx_ready = (tx_state == IDLE);
  assign tx_busy = ~tx_ready;
  assign tx_last = tick && tx_cnt == (tx_state == STOP ? STOP_LAST : OS_LAST);

  // transmit FSM; tx is registered so it changes together with the state
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      tx_state <= IDLE;
      tx_cnt <= '0;
      tx_n <= '0;
      tx_sh <= '0;
      tx <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par <= 1'b0;
`endif
    end else begin
      if (tick) tx_cnt <= tx_last ? '0 : tx_cnt + CW'(1);
      case (tx_state)
        IDLE: if (tx_valid) begin
          tx_state <= START;
          tx_cnt <= '0;
          tx_sh <= tx_data;
          tx <= 1'b0;
`ifdef UART_PARITY_EN
          tx_par <= ^tx_data ^ parity_odd;
`endif
        end
        START: if (tx_last) begin
          tx_state <= DATA;
          tx_n <= '0;
          tx <= tx_sh[0];
        end
        DATA: if (tx_last) begin
          tx_sh <= tx_sh >> 1;
          tx_n <= tx_n + NW'(1);
          if (tx_n == N_LAST) begin
`ifdef UART_PARITY_EN
            tx_state <= PARITY;
            tx <= tx_par;
`else
            tx_state <= STOP;
            tx <= 1'b1;
`endif
          end else tx <= tx_sh[1];
        end
        PARITY: if (tx_last) begin
          tx_state <= STOP;
          tx <= 1'b1;
        end
        STOP: if (tx_last) tx_state <= IDLE;
        default: tx_state <= IDLE;
      endcase
    end

  logic [2:0] rx_s;
  logic rx_line, rx_fall, rx_last, rx_done;
  uart_state_t rx_state;
  logic [CW-1:0] rx_cnt;
  logic [NW-1:0] rx_n;
  logic [DBITS-1:0] rx_sh;
`ifdef UART_PARITY_EN
  logic rx_par;
`endif
  assign rx_line = rx_s[1];
  assign rx_fall = rx_s[2] & ~rx_s[1];
  assign rx_last = tick && rx_cnt == (rx_state == START ? MID : OS_LAST);
  assign rx_done = (rx_state == STOP) && rx_last;

  // two-stage synchroniser plus one extra stage for falling-edge detection
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) rx_s <= 3'b111;
    else rx_s <= {rx_s[1:0], rx};

  // receive FSM; START waits to mid-bit, then every bit is sampled 16 ticks apart
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      rx_state <= IDLE;
      rx_cnt <= '0;
      rx_n <= '0;
      rx_sh <= '0;
`ifdef UART_PARITY_EN
      rx_par <= 1'b0;
`endif
    end else begin
      if (tick) rx_cnt <= rx_last ? '0 : rx_cnt + CW'(1);
      case (rx_state)
        IDLE: if (rx_fall) begin
          rx_state <= START;
          rx_cnt <= '0;
        end
        START: if (rx_last) begin
          rx_state <= rx_line ? IDLE : DATA;
          rx_n <= '0;
        end
        DATA: if (rx_last) begin
          rx_sh <= {rx_line, rx_sh[DBITS-1:1]};
          rx_n <= rx_n + NW'(1);
`ifdef UART_PARITY_EN
          if (rx_n == N_LAST) rx_state <= PARITY;
`else
          if (rx_n == N_LAST) rx_state <= STOP;
`endif
        end
        PARITY: if (rx_last) begin
`ifdef UART_PARITY_EN
          rx_par <= rx_line;
`endif
          rx_state <= STOP;
        end
        STOP: if (rx_last) rx_state <= IDLE;
        default: rx_state <= IDLE;
      endcase
    end

  // result holding register: a new frame always wins, overrun only if unacknowledged
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_frame_err <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (rx_done) begin
      rx_valid <= 1'b1;
      rx_data <= rx_sh;
      rx_frame_err <= ~rx_line;
`ifdef UART_PARITY_EN
      rx_parity_err <= ^rx_sh ^ parity_odd ^ rx_par;
`else
      rx_parity_err <= 1'b0;
`endif
      rx_overrun <= rx_valid & ~rx_ack;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun <= 1'b0;
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized self-checking bench for uart_core against a frame-level line model
module tb_uart_core;
  localparam int DBITS = 8;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = DBITS + PB + 2;

  logic PCLK = 1'b0, PRESET = 1'b1;
  logic [15:0] baud_div = '0;
`ifdef UART_PARITY_EN
  logic parity_odd = 1'b0;
`endif
  logic tx_valid = 1'b0;
  logic [DBITS-1:0] tx_data = '0;
  logic tx_ready, tx, tx_busy, rx, rx_valid, rx_frame_err, rx_parity_err, rx_overrun;
  logic rx_ack = 1'b0;
  logic [DBITS-1:0] rx_data;
  logic loop = 1'b0, rx_drv = 1'b1;
  logic [DBITS-1:0] q[$];
  int checks = 0, errors = 0;

  assign rx = loop ? tx : rx_drv;
  always #5 PCLK = ~PCLK;

  uart_core #(.DBITS(DBITS), .SB_TICK(16), .DIV_W(16)) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .baud_div(baud_div),
`ifdef UART_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tx(tx),
    .tx_busy(tx_busy),
    .rx(rx),
    .rx_valid(rx_valid),
    .rx_ack(rx_ack),
    .rx_data(rx_data),
    .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun)
  );

  // line level of bit i of a frame (start, data LSB first, optional parity, stop); bit flip is inverted
  function automatic logic frame_bit(input logic [DBITS-1:0] w, input int i, input int flip);
    logic b;
    b = (i == 0) ? 1'b0 : (i <= DBITS) ? w[i-1] : 1'b1;
`ifdef UART_PARITY_EN
    if (i == DBITS + 1) b = ^w ^ parity_odd;
`endif
    return b ^ (i == flip);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_tx(input logic [DBITS-1:0] w);
    int n = 0;
    while (!tx_ready && n < 5000) begin
      @(negedge PCLK);
      n++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 1);
    tx_valid = 1'b1;
    tx_data = w;
    @(negedge PCLK);
    tx_valid = 1'b0;
  endtask

  // with baud_div=0 every line level must last exactly 16 cycles
  task automatic tx_exact(input logic [DBITS-1:0] w);
    send_tx(w);
    for (int i = 0; i < NBITS * 16; i++) begin
      chk("tx_bit", 32'(tx), 32'(frame_bit(w, i / 16, -1)));
      chk("tx_ready_busy", 32'({tx_ready, tx_busy}), 32'b01);
      @(negedge PCLK);
    end
    chk("tx_end", 32'({tx_ready, tx_busy, tx}), 32'b101);
  endtask

  task automatic send_rx(input logic [DBITS-1:0] w, input int flip);
    for (int i = 0; i < NBITS; i++) begin
      rx_drv = frame_bit(w, i, flip);
      repeat (16 * (int'(baud_div) + 1)) @(negedge PCLK);
    end
    rx_drv = 1'b1;
  endtask

  task automatic recv(input logic [DBITS-1:0] w, input logic [2:0] flags);
    int n = 0;
    while (!rx_valid && n < 4000) begin
      @(negedge PCLK);
      n++;
    end
    chk("rx_valid", 32'(rx_valid), 1);
    chk("rx_data", 32'(rx_data), 32'(w));
    chk("rx_flags", 32'({rx_frame_err, rx_parity_err, rx_overrun}), 32'(flags));
    rx_ack = 1'b1;
    @(negedge PCLK);
    rx_ack = 1'b0;
    chk("rx_clear", 32'({rx_valid, rx_frame_err, rx_parity_err, rx_overrun}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    logic seen;
    logic [DBITS-1:0] w1, w2;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_tx", 32'({tx, tx_ready, tx_busy}), 32'b110);
    chk("rst_rx", 32'({rx_valid, rx_frame_err, rx_parity_err, rx_overrun}), 0);
    chk("rst_data", 32'(rx_data), 0);
`ifdef UART_PARITY_EN
    parity_odd = 1'($urandom_range(0, 1));
`endif
    tx_exact(8'hA5);
    repeat (3) tx_exact(DBITS'($urandom_range(0, 255)));
`ifdef UART_PARITY_EN
    parity_odd = 1'b0;
    tx_exact(8'h07);
`endif
    loop = 1'b1;
    baud_div = 16'($urandom_range(0, 2));
    q = {8'h3C, 8'hC3};
    repeat (6) q.push_back(DBITS'($urandom_range(0, 255)));
    fork
      foreach (q[k]) send_tx(q[k]);
      foreach (q[k]) recv(q[k], 3'b000);
    join
    repeat (20) @(negedge PCLK);
    loop = 1'b0;
    baud_div = 16'($urandom_range(0, 3));
    repeat (8) @(negedge PCLK);
    rx_drv = 1'b0;
    repeat (4 * (int'(baud_div) + 1)) @(negedge PCLK);
    rx_drv = 1'b1;
    seen = 1'b0;
    repeat (40 * (int'(baud_div) + 1)) begin
      @(negedge PCLK);
      seen |= rx_valid;
    end
    chk("glitch_no_valid", 32'(seen), 0);
    w1 = DBITS'($urandom_range(0, 255));
    send_rx(w1, -1);
    recv(w1, 3'b000);
    w1 = DBITS'($urandom_range(0, 255));
    send_rx(w1, NBITS - 1);
    recv(w1, 3'b100);
    w1 = DBITS'($urandom_range(0, 255));
    w2 = DBITS'($urandom_range(0, 255));
    send_rx(w1, -1);
    send_rx(w2, -1);
    recv(w2, 3'b001);
`ifdef UART_PARITY_EN
    w1 = DBITS'($urandom_range(0, 255));
    send_rx(w1, DBITS + 1);
    recv(w1, 3'b010);
`endif
    baud_div = '0;
    send_tx(DBITS'($urandom_range(0, 255)));
    repeat (40) @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    chk("rst_async_tx", 32'({tx, tx_ready, tx_busy}), 32'b110);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_release", 32'({tx, tx_ready, tx_busy}), 32'b110);
    tx_exact(DBITS'($urandom_range(0, 255)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_core.md
# uart_core

Full-duplex, parametrised UART engine for the serial subsystem on the PCLK domain. Replaces fixed-rate receive/transmit instances with one block that has a runtime-programmable baud divisor, a 16x-oversampled receiver with start-bit validation and error flags, a valid/ready transmit handshake, and optional parity. It sits between the bus-side register logic and the `tx`/`rx` pins.

## Interface
- `DBITS`, 8: data bits per frame, legal range 5–9.
- `SB_TICK`, 16: oversample ticks per stop period. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- `DIV_W`, 16: width of the baud divisor.

- `PCLK` in 1: single clock.
- `PRESET` in 1: asynchronous, active-high reset.
- `baud_div` in DIV_W: oversample tick period in PCLK cycles, minus 1. Set it to CLOCK_RATE/(16·BAUD)−1.
- `parity_odd` in 1: 1 selects odd parity, 0 selects even. Present only with `UART_PARITY_EN`.
- `tx_valid` in 1: transmit request.
- `tx_data` in DBITS: transmit word.
- `tx_ready` out 1: the engine can accept a word.
- `tx` out 1: serial output, idle high.
- `tx_busy` out 1: a frame is in progress.
- `rx` in 1: serial input, asynchronous.
- `rx_valid` out 1: a received word is held.
- `rx_ack` in 1: consume the held word.
- `rx_data` out DBITS: the received word.
- `rx_frame_err`, `rx_parity_err`, `rx_overrun` out 1 each: status of the held word.

## Operation
- Tick generator: down-counter loaded with `baud_div`. Emits a one-cycle `tick` when the count reaches 0, then reloads. A `baud_div` change takes effect at the next reload. `baud_div`=0 gives a tick every cycle.
- TX FSM has states IDLE, START, DATA, PARITY, STOP.
  - `tx_ready` = (state==IDLE).
  - A transfer is accepted when `tx_valid && tx_ready`; `tx_data` is latched into the shift register and the FSM goes to START.
  - START, each DATA bit and PARITY each last 16 ticks. STOP lasts SB_TICK ticks.
  - Data is sent LSB first. The PARITY state is skipped when the macro is absent.
  - `tx` is 0 in START, the data or parity bit in DATA/PARITY, and 1 in IDLE/STOP.
- RX FSM has states IDLE, START, DATA, PARITY, STOP.
  - `rx` passes through a 2-FF synchroniser first.
  - Falling edge in IDLE moves to START. After 7 ticks the synchronised line is re-sampled: if high, treat it as a glitch and return to IDLE with no flags; if low, continue.
  - Each subsequent bit is sampled every 16 ticks, at mid-bit.
  - The stop bit is sampled at mid-bit, then the FSM returns to IDLE immediately so back-to-back frames are caught.
- RX result register:
  - On frame completion, load `rx_data`, set `rx_frame_err` = (stop sample==0) and set `rx_parity_err` = (parity mismatch).
  - Set `rx_valid`=1. It stays high until `rx_ack` is sampled high, then clears the next cycle. The error flags clear with it.
  - If a frame completes while `rx_valid`=1 and no `rx_ack` arrives that cycle: the new word and its flags overwrite the old ones and `rx_overrun` is set.
  - `rx_overrun` is sticky until the next `rx_ack`.
  - A completion and an `rx_ack` in the same cycle: the new word wins, `rx_valid` stays 1 and there is no overrun.
- Parity bit = XOR of the data bits, XORed with `parity_odd`.

## Timing
- Reset values:
  - `tx`=1, `tx_ready`=1, `tx_busy`=0.
  - `rx_valid`=0, `rx_data`=0, all flags 0.
  - Both FSMs IDLE; tick counter loaded with 0.
- Reset mid-frame aborts immediately; `tx` returns high asynchronously.
- `tx` falls on the cycle after acceptance. `tx_busy` = !`tx_ready`.
- Bit period is 16·(`baud_div`+1) cycles.
- The tick counter is free-running, so first-bit phase jitter is up to one tick. This is acceptable by design.
- `rx_valid` rises one cycle after the stop-bit mid-sample tick.
- RX latency from the line: 2 synchroniser cycles plus the sampling point.

## Configuration
- `UART_PARITY_EN` defined:
  - The `parity_odd` port exists.
  - TX inserts a parity bit after the data bits.
  - RX samples the parity bit and drives `rx_parity_err`.
- `UART_PARITY_EN` undefined:
  - No PARITY state and no `parity_odd` port.
  - `rx_parity_err` is tied to 0.

## Structure
- Package `uart_pkg`:
  - Shared state enum `uart_state_t` (IDLE, START, DATA, PARITY, STOP).
  - Constant `OVERSAMPLE`=16.
  - Constant `START_MID`=7.
- Sub-module `uart_baud_tick`, the tick generator. TX and RX share one instance.
- TX and RX FSMs stay inline in `uart_core`.

## Test plan
- `baud_div`=0, send 0xA5 with parity off → `tx` shows 0,1,0,1,0,0,1,0,1,1, each level lasting 16 cycles, and `tx_ready` is low for 160 cycles.
- Loop `tx` to `rx` and send 0x3C then 0xC3 back to back with prompt `rx_ack` → `rx_data` is 0x3C then 0xC3, with no flags.
- Pulse `rx` low for 4 ticks, then hold it high → no `rx_valid`, and the RX FSM is back in IDLE.
- Send a frame on `rx` with the stop bit driven 0 → `rx_valid`=1 and `rx_frame_err`=1.
- Send two frames without `rx_ack` → `rx_data` holds the second word and `rx_overrun`=1; after `rx_ack`, all flags clear.
- With `UART_PARITY_EN` and `parity_odd`=0, send 0x07 → TX parity bit is 1. A corrupted parity bit on RX gives `rx_parity_err`=1.
- Assert `PRESET` during DATA → `tx`=1 immediately, `tx_ready`=1 after release, and the next frame is clean.
